// File: rtl/controlador_nonce.sv
// ----------------------------------------------------------------------------
// controlador_nonce
//
// Sequencing controller for the micro_ucr_hash datapath. An accepted start
// captures a 96-bit data block and an 8-bit target. The controller then feeds
// the datapath one 128-bit block per cycle, {datos, nonce}, with the nonce
// counting up from 0. A tag pipe of depth LATENCIA carries {valid, nonce} for
// every issued block, so each incoming H can be matched to the nonce that
// produced it. The search stops on the first hit, or once every nonce up to
// NONCE_LIMITE has been issued and its result has come back.
//
// Parameters:
//   LATENCIA      cycles from bloque to the matching H (0 = combinational)
//   NONCE_LIMITE  last nonce issued, inclusive
//
// Ports:
//   clk               clock, rising edge
//   inicio            synchronous active-low reset
//   arrancar          start pulse (accepted in REPOSO and HECHO only)
//   bloque_datos      96-bit data block, captured on start
//   target            8-bit difficulty, captured on start
//   H                 24-bit hash returned by the datapath
//   bloque            {datos_capturados, nonce}, nonce in [31:0]
//   valido_bloque     bloque carries a live nonce this cycle
//   ocupado           search or drain in progress
//   terminado         result available
//   encontrado        1 = hit, valid while terminado
//   nonce_encontrado  winning nonce
//   hash_encontrado   winning hash
// ----------------------------------------------------------------------------
module controlador_nonce #(
    parameter int          LATENCIA     = 2,
    parameter logic [31:0] NONCE_LIMITE = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         inicio,
    input  logic         arrancar,
    input  logic [95:0]  bloque_datos,
    input  logic [7:0]   target,
    input  logic [23:0]  H,
    output logic [127:0] bloque,
    output logic         valido_bloque,
    output logic         ocupado,
    output logic         terminado,
    output logic         encontrado,
    output logic [31:0]  nonce_encontrado,
    output logic [23:0]  hash_encontrado
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        BUSCANDO = 2'd1,
        DRENANDO = 2'd2,
        HECHO    = 2'd3
    } estado_t;

    estado_t     estado;
    estado_t     estado_sig;

    logic [95:0] datos_reg;
    logic [7:0]  target_reg;
    logic [31:0] nonce;

    logic        acepta;
    logic        tag_valido;
    logic [31:0] tag_nonce;
    logic        quedan;
    logic        hay_hit;

    assign bloque = {datos_reg, nonce};

    generate
        if (LATENCIA == 0) begin : g_directo
            // Combinational datapath: the block on the bus right now is the
            // one whose hash is arriving, and nothing is ever in flight.
            assign tag_valido = valido_bloque;
            assign tag_nonce  = nonce;
            assign quedan     = 1'b0;
        end else begin : g_pipe
            logic [32:0] pipe [LATENCIA];

            // Tag pipe: one {valid, nonce} entry per issued block. It is
            // flushed on a new start so tags discarded after a hit can never
            // be matched against hashes of the next search.
            always_ff @(posedge clk) begin
                if (!inicio || acepta) begin
                    for (int i = 0; i < LATENCIA; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= {valido_bloque, nonce};
                    for (int i = 1; i < LATENCIA; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign tag_valido = pipe[LATENCIA-1][32];
            assign tag_nonce  = pipe[LATENCIA-1][31:0];

            // Tags still behind the pipe output; the output entry itself is
            // consumed this cycle, so it does not count as remaining.
            always_comb begin
                quedan = 1'b0;
                for (int i = 0; i < LATENCIA - 1; i++) begin
                    quedan = quedan | pipe[i][32];
                end
            end
        end
    endgenerate

    // Only results returning during a search or drain are considered; both
    // hash bytes must be strictly below the captured target.
    assign hay_hit = tag_valido
                   && ((estado == BUSCANDO) || (estado == DRENANDO))
                   && (H[23:16] < target_reg)
                   && (H[15:8]  < target_reg);

    always_comb begin
        estado_sig = estado;
        acepta     = 1'b0;
        case (estado)
            REPOSO, HECHO: begin
                if (arrancar) begin
                    acepta     = 1'b1;
                    estado_sig = (target == 8'd0) ? HECHO : BUSCANDO;
                end
            end
            BUSCANDO: begin
                if (hay_hit) begin
                    estado_sig = HECHO;
                end else if (nonce == NONCE_LIMITE) begin
                    // With no latency there is nothing left to drain.
                    estado_sig = (LATENCIA == 0) ? HECHO : DRENANDO;
                end
            end
            DRENANDO: begin
                if (hay_hit || !quedan) begin
                    estado_sig = HECHO;
                end
            end
            default: estado_sig = REPOSO;
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // the state they describe. A start clears the previous result; a hit
    // latches the tag and hash seen at the pipe output.
    always_ff @(posedge clk) begin
        if (!inicio) begin
            estado           <= REPOSO;
            datos_reg        <= '0;
            target_reg       <= '0;
            nonce            <= '0;
            valido_bloque    <= 1'b0;
            ocupado          <= 1'b0;
            terminado        <= 1'b0;
            encontrado       <= 1'b0;
            nonce_encontrado <= '0;
            hash_encontrado  <= '0;
        end else begin
            estado        <= estado_sig;
            valido_bloque <= (estado_sig == BUSCANDO);
            ocupado       <= (estado_sig == BUSCANDO) || (estado_sig == DRENANDO);
            terminado     <= (estado_sig == HECHO);
            if (acepta) begin
                datos_reg        <= bloque_datos;
                target_reg       <= target;
                nonce            <= '0;
                encontrado       <= 1'b0;
                nonce_encontrado <= '0;
                hash_encontrado  <= '0;
            end else begin
                if ((estado == BUSCANDO) && (estado_sig == BUSCANDO)) begin
                    nonce <= nonce + 32'd1;
                end
                if (hay_hit) begin
                    encontrado       <= 1'b1;
                    nonce_encontrado <= tag_nonce;
                    hash_encontrado  <= H;
                end
            end
        end
    end

endmodule

// File: tb/tb_controlador_nonce.sv
// ----------------------------------------------------------------------------
// tb_controlador_nonce
//
// Two controllers share one stimulus stream: dut_a with LATENCIA=2 and
// NONCE_LIMITE=7, dut_b with LATENCIA=0 and NONCE_LIMITE=15. Each has its own
// datapath stand-in returning hashes from a per-nonce table. Every start
// pushes the expected block stream and the expected result of each DUT into
// scoreboard queues; a monitor on the falling edge pops and compares whenever
// a DUT shows a live block or a fresh result.
// ----------------------------------------------------------------------------
module tb_controlador_nonce;

   typedef struct {
      int          d;
      logic        encontrado;
      logic [31:0] nonce;
      logic [23:0] hash;
      int          cyc;
   } exp_t;

   typedef struct {
      int           d;
      logic [127:0] dato;
      int           cyc;
   } blq_t;

   logic         clk = 1'b0;
   logic         inicio;
   logic         arrancar;
   logic [95:0]  bloque_datos;
   logic [7:0]   target;
   logic [23:0]  h_a;
   logic [23:0]  h_b;

   logic [127:0] bloque_o [2];
   logic         valido_o [2];
   logic         ocupado_o [2];
   logic         terminado_o [2];
   logic         encontrado_o [2];
   logic [31:0]  nonce_enc_o [2];
   logic [23:0]  hash_enc_o [2];

   logic [23:0]  tabla [16];
   logic [31:0]  dl1;
   logic [31:0]  dl2;
   logic         arr_muestreado;
   logic         term_prev [2];

   exp_t         res_q [$];
   blq_t         blq_q [$];

   int           cyc = 0;
   int           checks = 0;
   int           errores = 0;

   controlador_nonce #(.LATENCIA(2), .NONCE_LIMITE(32'd7)) dut_a (
      .clk              (clk),
      .inicio           (inicio),
      .arrancar         (arrancar),
      .bloque_datos     (bloque_datos),
      .target           (target),
      .H                (h_a),
      .bloque           (bloque_o[0]),
      .valido_bloque    (valido_o[0]),
      .ocupado          (ocupado_o[0]),
      .terminado        (terminado_o[0]),
      .encontrado       (encontrado_o[0]),
      .nonce_encontrado (nonce_enc_o[0]),
      .hash_encontrado  (hash_enc_o[0])
   );

   controlador_nonce #(.LATENCIA(0), .NONCE_LIMITE(32'd15)) dut_b (
      .clk              (clk),
      .inicio           (inicio),
      .arrancar         (arrancar),
      .bloque_datos     (bloque_datos),
      .target           (target),
      .H                (h_b),
      .bloque           (bloque_o[1]),
      .valido_bloque    (valido_o[1]),
      .ocupado          (ocupado_o[1]),
      .terminado        (terminado_o[1]),
      .encontrado       (encontrado_o[1]),
      .nonce_encontrado (nonce_enc_o[1]),
      .hash_encontrado  (hash_enc_o[1])
   );

   // Free-running clock and a cycle counter stepped on every rising edge.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc            <= cyc + 1;
      arr_muestreado <= arrancar;
   end

   // Datapath stand-ins: dut_a sees the hash of the nonce it issued two
   // cycles earlier, dut_b sees the hash of the nonce on the bus right now.
   always @(posedge clk) begin
      dl1 <= bloque_o[0][31:0];
      dl2 <= dl1;
   end

   assign h_a = (dl2 < 32'd16) ? tabla[dl2[3:0]] : 24'hFFFFFF;
   assign h_b = (bloque_o[1][31:0] < 32'd16) ? tabla[bloque_o[1][3:0]] : 24'hFFFFFF;

   task automatic checkOutput(input string nombre, input int d,
                              input logic [127:0] actual, input logic [127:0] esperado);
      checks++;
      if (actual !== esperado) begin
         errores++;
         $display("[TB] FAIL %s dut%0d: actual=%0h esperado=%0h", nombre, d, actual, esperado);
      end
   endtask

   function automatic bit esGolpe(input logic [23:0] h, input logic [7:0] t);
      return (h[23:16] < t) && (h[15:8] < t);
   endfunction

   // Reference model: scan the table for the first qualifying nonce and
   // derive the block stream and completion cycle from the timing rules.
   task automatic modelo(input int d, input int t0);
      int   lat;
      int   lim;
      int   ultimo;
      exp_t e;
      blq_t b;
      lat          = (d == 0) ? 2 : 0;
      lim          = (d == 0) ? 7 : 15;
      e.d          = d;
      e.encontrado = 1'b0;
      e.nonce      = '0;
      e.hash       = '0;
      if (target == 8'd0) begin
         e.cyc = t0 + 1;
         res_q.push_back(e);
         return;
      end
      ultimo = lim;
      e.cyc  = t0 + 1 + lim + lat + 1;
      for (int n = 0; n <= lim; n++) begin
         if (esGolpe(tabla[n], target)) begin
            e.encontrado = 1'b1;
            e.nonce      = 32'(n);
            e.hash       = tabla[n];
            e.cyc        = t0 + 1 + n + lat + 1;
            ultimo       = (n + lat < lim) ? n + lat : lim;
            break;
         end
      end
      for (int n = 0; n <= ultimo; n++) begin
         b.d    = d;
         b.dato = {bloque_datos, 32'(n)};
         b.cyc  = t0 + 1 + n;
         blq_q.push_back(b);
      end
      res_q.push_back(e);
   endtask

   function automatic int primeroRes(input int d);
      for (int i = 0; i < res_q.size(); i++) begin
         if (res_q[i].d == d) return i;
      end
      return -1;
   endfunction

   function automatic int primeroBlq(input int d);
      for (int i = 0; i < blq_q.size(); i++) begin
         if (blq_q[i].d == d) return i;
      end
      return -1;
   endfunction

   function automatic int contarBlq(input int d);
      int c;
      c = 0;
      for (int i = 0; i < blq_q.size(); i++) begin
         if (blq_q[i].d == d) c++;
      end
      return c;
   endfunction

   task automatic purgarBlq(input int d);
      for (int i = blq_q.size() - 1; i >= 0; i--) begin
         if (blq_q[i].d == d) blq_q.delete(i);
      end
   endtask

   // Monitor: a live block must match the next expected block of that DUT;
   // a fresh result (terminado rising, or re-asserted right after a start)
   // must match the next expected result.
   always @(negedge clk) begin : monitor
      int   idx;
      exp_t e;
      blq_t b;
      for (int d = 0; d < 2; d++) begin
         if (inicio) begin
            if (valido_o[d]) begin
               idx = primeroBlq(d);
               if (idx < 0) begin
                  checkOutput("valido inesperado", d, 128'(valido_o[d]), 128'(0));
               end else begin
                  b = blq_q[idx];
                  blq_q.delete(idx);
                  checkOutput("bloque", d, bloque_o[d], b.dato);
                  checkOutput("ciclo bloque", d, 128'(cyc), 128'(b.cyc));
                  checkOutput("ocupado en busqueda", d, 128'(ocupado_o[d]), 128'(1));
                  checkOutput("terminado en busqueda", d, 128'(terminado_o[d]), 128'(0));
               end
            end
            if (terminado_o[d] && (!term_prev[d] || arr_muestreado)) begin
               idx = primeroRes(d);
               if (idx < 0) begin
                  checkOutput("terminado inesperado", d, 128'(terminado_o[d]), 128'(0));
               end else begin
                  e = res_q[idx];
                  res_q.delete(idx);
                  checkOutput("encontrado", d, 128'(encontrado_o[d]), 128'(e.encontrado));
                  checkOutput("nonce_encontrado", d, 128'(nonce_enc_o[d]), 128'(e.nonce));
                  checkOutput("hash_encontrado", d, 128'(hash_enc_o[d]), 128'(e.hash));
                  checkOutput("ciclo terminado", d, 128'(cyc), 128'(e.cyc));
                  checkOutput("ocupado en hecho", d, 128'(ocupado_o[d]), 128'(0));
                  checkOutput("valido en hecho", d, 128'(valido_o[d]), 128'(0));
                  checkOutput("bloques pendientes", d, 128'(contarBlq(d)), 128'(0));
                  purgarBlq(d);
               end
            end
         end
         term_prev[d] = terminado_o[d];
      end
   end

   task automatic tablaSin();
      for (int n = 0; n < 16; n++) tabla[n] = 24'hFFFFFF;
   endtask

   task automatic llenarTabla(input int tgt);
      for (int n = 0; n < 16; n++) begin
         int alto;
         int medio;
         int bajo;
         bajo = int'($urandom_range(0, 255));
         if (tgt > 0 && $urandom_range(0, 7) == 0) begin
            alto  = int'($urandom_range(0, tgt - 1));
            medio = int'($urandom_range(0, tgt - 1));
         end else if ($urandom_range(0, 1) == 1) begin
            alto  = int'($urandom_range(tgt, 255));
            medio = int'($urandom_range(0, 255));
         end else begin
            alto  = int'($urandom_range(0, 255));
            medio = int'($urandom_range(tgt, 255));
         end
         tabla[n] = {8'(alto), 8'(medio), 8'(bajo)};
      end
   endtask

   task automatic revisarCeros(input string nombre);
      for (int d = 0; d < 2; d++) begin
         checkOutput({nombre, " bloque"}, d, bloque_o[d], 128'(0));
         checkOutput({nombre, " valido"}, d, 128'(valido_o[d]), 128'(0));
         checkOutput({nombre, " ocupado"}, d, 128'(ocupado_o[d]), 128'(0));
         checkOutput({nombre, " terminado"}, d, 128'(terminado_o[d]), 128'(0));
         checkOutput({nombre, " encontrado"}, d, 128'(encontrado_o[d]), 128'(0));
         checkOutput({nombre, " nonce"}, d, 128'(nonce_enc_o[d]), 128'(0));
         checkOutput({nombre, " hash"}, d, 128'(hash_enc_o[d]), 128'(0));
      end
   endtask

   // Called just after a falling edge; returns just after the next one.
   task automatic arrancarBusqueda(input logic [95:0] datos, input logic [7:0] tgt);
      int t0;
      bloque_datos = datos;
      target       = tgt;
      arrancar     = 1'b1;
      t0           = cyc;
      modelo(0, t0);
      modelo(1, t0);
      @(negedge clk);
      #1;
      arrancar = 1'b0;
   endtask

   task automatic esperarFin();
      for (int i = 0; i < 300 && res_q.size() != 0; i++) @(negedge clk);
      #1;
      if (res_q.size() != 0) begin
         checkOutput("timeout resultados", 0, 128'(res_q.size()), 128'(0));
         res_q.delete();
         blq_q.delete();
      end
   endtask

   task automatic applyStimulus(input logic [95:0] datos, input logic [7:0] tgt);
      arrancarBusqueda(datos, tgt);
      esperarFin();
   endtask

   initial begin
      inicio       = 1'b0;
      arrancar     = 1'b0;
      bloque_datos = '0;
      target       = '0;
      term_prev[0] = 1'b0;
      term_prev[1] = 1'b0;
      tablaSin();
      repeat (3) @(negedge clk);
      #1;
      revisarCeros("reset");
      inicio = 1'b1;
      @(negedge clk);
      #1;

      $display("[TB] acierto en nonce 5");
      tablaSin();
      tabla[5] = 24'h0A0BFF;
      applyStimulus(96'h1111_2222_3333_4444_5555_6666, 8'h10);

      $display("[TB] agotamiento sin aciertos");
      tablaSin();
      applyStimulus(96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF, 8'h10);

      $display("[TB] acierto en el ultimo nonce");
      tablaSin();
      tabla[7] = 24'h010203;
      applyStimulus(96'h0123_4567_89AB_CDEF_0011_2233, 8'h10);

      $display("[TB] acierto en nonce 3");
      tablaSin();
      tabla[3] = 24'h0F0F00;
      applyStimulus(96'hDEAD_BEEF_CAFE_F00D_1234_5678, 8'h10);

      $display("[TB] target cero desde HECHO");
      tablaSin();
      tabla[2] = 24'h000000;
      applyStimulus(96'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A, 8'h00);

      $display("[TB] arrancar ignorado durante la busqueda");
      tablaSin();
      tabla[6] = 24'h1F1FFF;
      arrancarBusqueda(96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 8'h20);
      repeat (2) @(negedge clk);
      #1;
      bloque_datos = 96'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0;
      target       = 8'h00;
      arrancar     = 1'b1;
      @(negedge clk);
      #1;
      arrancar = 1'b0;
      esperarFin();

      $display("[TB] reset a mitad de busqueda");
      tablaSin();
      arrancarBusqueda(96'h7777_7777_7777_7777_7777_7777, 8'h40);
      repeat (3) @(negedge clk);
      #1;
      inicio = 1'b0;
      @(negedge clk);
      #1;
      revisarCeros("reset en busqueda");
      res_q.delete();
      blq_q.delete();
      inicio = 1'b1;
      @(negedge clk);
      #1;
      tabla[4] = 24'h3A01FF;
      applyStimulus(96'h8888_9999_AAAA_BBBB_CCCC_DDDD, 8'h40);

      $display("[TB] busquedas aleatorias");
      for (int k = 0; k < 24; k++) begin
         logic [7:0] tgt;
         tgt = 8'($urandom_range(0, 255));
         llenarTabla(int'(tgt));
         applyStimulus({$urandom, $urandom, $urandom}, tgt);
      end

      $display("Result: errors=%0d of %0d checks", errores, checks);
      $finish;
   end

endmodule
